intan_multiport_acq: RTL and testbench

// Parametrised Intan SPI acquisition engine driving one COPI and receiving N_CIPO DDR CIPO lines.

---
 rtl/intan_multiport_acq.sv | 214 +++++++++++++++++++++
 tb/tb_intan_multiport_acq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intan_multiport_acq.sv
// Intan SPI acquisition engine: one COPI, N_CIPO DDR CIPO lines with per-line delay,
// frame/header streaming over valid/ready with overrun accounting.
module intan_multiport_acq #(
    parameter int N_CIPO    = 4,
    parameter int N_CMDS    = 35,
    parameter int MAX_DELAY = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  ts_reset,
    input  logic [31:0]           loop_count,
    input  logic                  debug_mode,
    input  logic [4*N_CIPO-1:0]   cipo_delay,
    output logic [5:0]            cmd_addr,
    input  logic [15:0]           cmd_word,
    input  logic [N_CIPO-1:0]     cipo,
    output logic                  csn,
    output logic                  sclk,
    output logic                  copi,
    output logic                  m_valid,
    output logic [31:0]           m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  active,
    output logic                  loop_done,
    output logic [31:0]           frames_sent,
    output logic [15:0]           overrun_count,
    output logic [63:0]           timestamp
);

    // state | meaning
    // 0     | header slot (cycle 0 of an active frame)
    // 0-63  | sclk toggles, copi shifts the command word MSB first
    // 64-65 | csn held low, bus idle
    // 76    | command address advances to the next cycle index
    // 78    | captured words of all lines move into the output buffer
    // 79    | command word latched; cycle advances (frame boundary on last cycle)

    localparam int         DEPTH    = N_CIPO + 4;
    localparam int         CW       = $clog2(DEPTH + 1);
    localparam logic [5:0] LAST_CYC = 6'(N_CMDS - 1);
    localparam logic [3:0] DMAX     = 4'(MAX_DELAY);

    logic [6:0]  r_state, w_state_nxt;
    logic [5:0]  r_cycle, w_cycle_nxt;
    logic        w_boundary;

    logic        r_active, r_en_q;
    logic [31:0] r_fs, w_fs_nxt;
    logic        w_en_rise, w_done_nxt;
    logic [63:0] r_ts;
    logic [15:0] r_cmd;
    logic [5:0]  r_cmd_addr;
    logic [15:0] r_ovr;

    logic        r_csn, r_sclk, r_copi;
    logic        w_csn_d, w_sclk_d, w_copi_d, w_spi_on;
    logic        w_hdr_slot, w_blk_slot;

    logic [15:0] r_a [N_CIPO];
    logic [15:0] r_b [N_CIPO];
    logic [6:0]  w_rel [N_CIPO];
    logic [N_CIPO-1:0] w_samp_a, w_samp_b;

    logic [32:0]   r_q [DEPTH];
    logic [32:0]   w_q_nxt [DEPTH];
    logic [CW-1:0] r_cnt, w_cnt_pop, w_cnt_nxt;
    logic [32:0]   w_hdr [4];
    logic [32:0]   w_blk [N_CIPO];
    logic          w_pop, w_hdr_push, w_hdr_drop, w_blk_push, w_blk_drop;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= 7'd0;
            r_cycle <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cycle <= w_cycle_nxt;
        end
    end

    always_comb begin
        w_state_nxt = (r_state == 7'd79) ? 7'd0 : r_state + 7'd1;
        w_cycle_nxt = r_cycle;
        if (r_state == 7'd79)
            w_cycle_nxt = (r_cycle == LAST_CYC) ? 6'd0 : r_cycle + 6'd1;
    end

    always_comb begin
        w_spi_on   = r_active && (r_state <= 7'd63);
        w_csn_d    = !(r_active && (r_state <= 7'd65));
        w_sclk_d   = w_spi_on && r_state[1];
        w_copi_d   = w_spi_on && r_cmd[~r_state[5:2]];
        w_hdr_slot = r_active && (r_state == 7'd0) && (r_cycle == 6'd0);
        w_blk_slot = r_active && (r_state == 7'd78);
    end

    assign w_boundary = (r_state == 7'd79) && (r_cycle == LAST_CYC);
    assign w_en_rise  = enable && !r_en_q;
    assign w_fs_nxt   = w_en_rise ? 32'd0 : ((w_boundary && r_active) ? r_fs + 32'd1 : r_fs);
    assign w_done_nxt = (loop_count != 32'd0) && (w_fs_nxt >= loop_count);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_active   <= 1'b0;
            r_en_q     <= 1'b0;
            r_fs       <= 32'd0;
            r_ts       <= 64'd0;
            r_cmd      <= 16'd0;
            r_cmd_addr <= 6'd0;
            r_csn      <= 1'b1;
            r_sclk     <= 1'b0;
            r_copi     <= 1'b0;
        end else begin
            r_en_q <= enable;
            r_fs   <= w_fs_nxt;
            r_csn  <= w_csn_d;
            r_sclk <= w_sclk_d;
            r_copi <= w_copi_d;
            if (w_boundary) begin
                r_ts     <= (!enable && ts_reset) ? 64'd0 : r_ts + 64'd1;
                r_active <= enable && !w_done_nxt;
            end
            if (r_state == 7'd79)
                r_cmd <= cmd_word;
            if (r_state == 7'd76)
                r_cmd_addr <= (r_cycle == LAST_CYC) ? 6'd0 : r_cycle + 6'd1;
        end
    end

    // Sample points are referenced to the delayed state; a wrapped subtraction lands above 65.
    always_comb begin
        for (int k = 0; k < N_CIPO; k++) begin
            w_rel[k]    = r_state - {3'd0, ((cipo_delay[4*k +: 4] > DMAX) ? DMAX : cipo_delay[4*k +: 4])};
            w_samp_a[k] = (w_rel[k] >= 7'd3) && (w_rel[k] <= 7'd63) && (w_rel[k][1:0] == 2'b11);
            w_samp_b[k] = (w_rel[k] >= 7'd5) && (w_rel[k] <= 7'd65) && (w_rel[k][1:0] == 2'b01);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_CIPO; k++) begin
            if (w_samp_a[k]) r_a[k] <= {r_a[k][14:0], cipo[k]};
            if (w_samp_b[k]) r_b[k] <= {r_b[k][14:0], cipo[k]};
        end
    end

    always_comb begin
        w_hdr[0] = {1'b0, 32'hDEADBEEF};
        w_hdr[1] = {1'b0, 32'hCAFEBABE};
        w_hdr[2] = {1'b0, r_ts[31:0]};
        w_hdr[3] = {1'b0, r_ts[63:32]};
        for (int k = 0; k < N_CIPO; k++) begin
            w_blk[k][32]   = (r_cycle == LAST_CYC) && (k == N_CIPO - 1);
            w_blk[k][31:0] = debug_mode ? {4'hD, 4'(k), 2'b00, r_cycle, r_ts[15:0]}
                                        : {r_b[k], r_a[k]};
        end
    end

    assign w_pop      = m_valid && m_ready;
    assign w_cnt_pop  = r_cnt - {{(CW-1){1'b0}}, w_pop};
    assign w_hdr_push = w_hdr_slot && (w_cnt_pop <= CW'(DEPTH - 4));
    assign w_hdr_drop = w_hdr_slot && !w_hdr_push;
    assign w_blk_push = w_blk_slot && (w_cnt_pop == '0);
    assign w_blk_drop = w_blk_slot && !w_blk_push;
    assign w_cnt_nxt  = w_cnt_pop + (w_hdr_push ? CW'(4) : '0) + (w_blk_push ? CW'(N_CIPO) : '0);

    // Shift queue: entry 0 is the head; pushes land right behind whatever survives the pop.
    always_comb begin
        for (int j = 0; j < DEPTH; j++)
            w_q_nxt[j] = r_q[j];
        if (w_pop)
            for (int j = 0; j < DEPTH - 1; j++)
                w_q_nxt[j] = r_q[j+1];
        if (w_hdr_push)
            for (int j = 0; j < DEPTH; j++)
                for (int i = 0; i < 4; i++)
                    if (j >= i && w_cnt_pop == CW'(j - i))
                        w_q_nxt[j] = w_hdr[i];
        if (w_blk_push)
            for (int i = 0; i < N_CIPO; i++)
                w_q_nxt[i] = w_blk[i];
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < DEPTH; j++)
            r_q[j] <= w_q_nxt[j];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_ovr <= 16'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if ((w_hdr_drop || w_blk_drop) && (r_ovr != 16'hFFFF))
                r_ovr <= r_ovr + 16'd1;
        end
    end

    assign m_valid       = (r_cnt != '0);
    assign m_data        = m_valid ? r_q[0][31:0] : 32'd0;
    assign m_last        = m_valid && r_q[0][32];
    assign csn           = r_csn;
    assign sclk          = r_sclk;
    assign copi          = r_copi;
    assign cmd_addr      = r_cmd_addr;
    assign active        = r_active;
    assign frames_sent   = r_fs;
    assign loop_done     = (loop_count != 32'd0) && (r_fs >= loop_count);
    assign overrun_count = r_ovr;
    assign timestamp     = r_ts;

endmodule

// File: tb/tb_intan_multiport_acq.sv
// Randomized bench for intan_multiport_acq with a word-queue reference model of the
// frame schedule, headstage CIPO timing and output stream.
module tb_intan_multiport_acq;
    localparam int N  = 4;
    localparam int NC = 35;
    localparam int MD = 12;

    logic            clk = 1'b0;
    logic            rstn, enable, ts_reset, debug_mode, m_ready;
    logic [31:0]     loop_count;
    logic [4*N-1:0]  cipo_delay;
    logic [5:0]      cmd_addr;
    logic [15:0]     cmd_word;
    logic [N-1:0]    cipo;
    logic            csn, sclk, copi, m_valid, m_last, active, loop_done;
    logic [31:0]     m_data, frames_sent;
    logic [15:0]     overrun_count;
    logic [63:0]     timestamp;

    intan_multiport_acq #(.N_CIPO(N), .N_CMDS(NC), .MAX_DELAY(MD)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .ts_reset(ts_reset),
        .loop_count(loop_count), .debug_mode(debug_mode), .cipo_delay(cipo_delay),
        .cmd_addr(cmd_addr), .cmd_word(cmd_word), .cipo(cipo),
        .csn(csn), .sclk(sclk), .copi(copi),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .active(active), .loop_done(loop_done), .frames_sent(frames_sent),
        .overrun_count(overrun_count), .timestamp(timestamp)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          cyc;
        int          line;
        bit          hdr;
    } ent_t;

    ent_t        q[$];
    int          ms, mc;
    bit          mact, men_q;
    logic [31:0] mfs;
    logic [63:0] mts;
    logic [15:0] movr, mcmd;
    logic [5:0]  maddr;
    logic [2:0]  mspi;
    logic [15:0] wa [N];
    logic [15:0] wb [N];
    logic [15:0] cmd_mem [64];
    int          dly [N];
    bit          fixed_pat;
    int          ready_mode;
    int          lasts;
    logic [31:0] dbg_seen;

    task automatic model_reset();
        ms = 0; mc = 0; mact = 0; men_q = 0;
        mfs = '0; mts = '0; movr = '0; mcmd = '0; maddr = '0;
        mspi = 3'b100;
        q.delete();
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
        for (int k = 0; k < N; k++) cipo_delay[4*k +: 4] = 4'(dly[k]);
    endtask

    task automatic sat_inc();
        if (movr != 16'hFFFF) movr = movr + 16'd1;
    endtask

    task automatic step();
        ent_t        e;
        int          d, rel;
        bit          pop, en_rise, on;
        logic [31:0] fsn;
        logic [127:0] exp_s;
        @(negedge clk);
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(3) != 0);
            default: m_ready = 1'b0;
        endcase
        cmd_word = cmd_mem[cmd_addr];
        if (ms == 0)
            for (int k = 0; k < N; k++) begin
                wa[k] = fixed_pat ? 16'h1234 : 16'($urandom);
                wb[k] = fixed_pat ? 16'h5678 : 16'($urandom);
            end
        for (int k = 0; k < N; k++) begin
            d   = (dly[k] > MD) ? MD : dly[k];
            rel = ms - d;
            if (rel >= 3 && rel <= 63 && rel % 4 == 3)
                cipo[k] = wa[k][15 - (rel - 3) / 4];
            else if (rel >= 5 && rel <= 65 && rel % 4 == 1)
                cipo[k] = wb[k][15 - (rel - 5) / 4];
            else
                cipo[k] = 1'($urandom_range(1));
        end
        if (rstn && m_valid && m_ready) begin
            if (m_last) lasts++;
            if (q.size() > 0 && !q[0].hdr && q[0].cyc == 5 && q[0].line == 2 && debug_mode)
                dbg_seen = m_data;
        end
        if (!rstn) begin
            model_reset();
        end else begin
            pop = (q.size() > 0) && m_ready;
            on  = mact && ms <= 63;
            mspi[2] = !(mact && ms <= 65);
            mspi[1] = on && ((ms & 2) != 0);
            mspi[0] = on ? mcmd[15 - ms / 4] : 1'b0;
            if (pop) void'(q.pop_front());
            if (mact && ms == 0 && mc == 0) begin
                if (q.size() <= N) begin
                    e.l = 1'b0; e.hdr = 1'b1; e.cyc = 0; e.line = 0;
                    e.d = 32'hDEADBEEF;  q.push_back(e);
                    e.d = 32'hCAFEBABE;  q.push_back(e);
                    e.d = mts[31:0];     q.push_back(e);
                    e.d = mts[63:32];    q.push_back(e);
                end else sat_inc();
            end
            if (mact && ms == 78) begin
                if (q.size() == 0) begin
                    for (int k = 0; k < N; k++) begin
                        e.hdr = 1'b0; e.cyc = mc; e.line = k;
                        e.l   = (mc == NC - 1) && (k == N - 1);
                        e.d   = debug_mode ? {4'hD, 4'(k), 2'b00, 6'(mc), mts[15:0]} : {wb[k], wa[k]};
                        q.push_back(e);
                    end
                end else sat_inc();
            end
            en_rise = enable && !men_q;
            men_q   = enable;
            fsn     = en_rise ? 32'd0 : mfs;
            if (ms == 79 && mc == NC - 1) begin
                fsn  = en_rise ? 32'd0 : mfs + (mact ? 32'd1 : 32'd0);
                mts  = (!enable && ts_reset) ? 64'd0 : mts + 64'd1;
                mact = enable && !(loop_count != 0 && fsn >= loop_count);
            end
            mfs = fsn;
            if (ms == 76) maddr = (mc == NC - 1) ? 6'd0 : 6'(mc + 1);
            if (ms == 79) begin
                mcmd = cmd_word;
                mc   = (mc == NC - 1) ? 0 : mc + 1;
            end
            ms = (ms == 79) ? 0 : ms + 1;
        end
        @(posedge clk);
        #1;
        chk("spi", {csn, sclk, copi}, mspi);
        exp_s = '0;
        if (q.size() > 0) exp_s = {1'b1, q[0].l, q[0].d};
        chk("stream", {m_valid, m_last, m_data}, exp_s);
        chk("status", {active, loop_done, frames_sent, overrun_count, timestamp, cmd_addr},
            {mact, (loop_count != 0 && mfs >= loop_count), mfs, movr, mts, maddr});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int s, input int c, input int budget);
        int i;
        i = 0;
        do begin
            step();
            i++;
        end while (!(ms == s && mc == c) && i < budget);
        if (!(ms == s && mc == c)) chk("timeout", 1, 0);
    endtask

    logic [15:0] ovr0;

    initial begin
        rstn = 1'b0; enable = 1'b0; ts_reset = 1'b0; debug_mode = 1'b0;
        loop_count = 32'd0; cmd_word = '0; cipo = '0; m_ready = 1'b1;
        ready_mode = 0; fixed_pat = 1; lasts = 0; dbg_seen = '0;
        set_dly(0, 3, 7, 12);
        for (int i = 0; i < 64; i++) cmd_mem[i] = 16'($urandom);
        model_reset();
        run(4);
        rstn = 1'b1;

        // three-frame loop: fixed pattern in the first frame, random afterwards
        enable = 1'b1; loop_count = 32'd3;
        run_until(0, 0, 2900);
        run_until(0, 0, 2900);
        fixed_pat = 0;
        run_until(0, 0, 2900);
        run_until(0, 0, 2900);
        run(2900);
        chk("frames_with_last", lasts, 3);
        chk("loop_done", {loop_done, active, csn}, 3'b101);

        // re-arm with clamped delays, random back-pressure and a 200 clk stall
        enable = 1'b0; step();
        enable = 1'b1; loop_count = 32'd0; ready_mode = 1;
        set_dly(15, 13, 12, 1);
        run_until(0, 0, 2900);
        run_until(70, 5, 2900);
        ovr0 = overrun_count;
        ready_mode = 2;
        run(200);
        ready_mode = 1;
        run_until(0, 10, 2900);
        chk("ovr_delta", overrun_count - ovr0, 16'd2);

        // enable drops in cycle 10: frame completes, then timestamp is zeroed
        enable = 1'b0; ts_reset = 1'b1;
        run_until(0, 0, 2900);
        ts_reset = 1'b0;
        run(10);
        chk("ts_zero", timestamp, 64'd0);
        chk("last_after_disable", lasts, 4);
        chk("idle_after_disable", {active, csn}, 2'b01);

        // idle frames until the timestamp reaches 6, then one debug frame at ts=7
        for (int i = 0; i < 6; i++) run_until(0, 0, 2900);
        enable = 1'b1; debug_mode = 1'b1; ready_mode = 0;
        run_until(0, 0, 2900);
        chk("ts7", timestamp, 64'd7);
        run_until(10, 6, 2900);
        chk("dbg_word", dbg_seen, 32'hD2050007);

        // reset with a block stuck in the buffer, mid-frame at state 40
        ready_mode = 2;
        run_until(40, 7, 2900);
        rstn = 1'b0;
        step();
        chk("rst_out", {csn, sclk, copi, m_valid, m_last, m_data, active, cmd_addr, overrun_count, frames_sent},
            {3'b100, 2'b00, 32'd0, 1'b0, 6'd0, 16'd0, 32'd0});
        rstn = 1'b1; ready_mode = 0; enable = 1'b0; debug_mode = 1'b0;
        run(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
